// File: rtl/riscv_irq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// riscv_irq_ctrl_pkg
// Shared definitions for the RISC-V interrupt controller:
//   - register map addresses for the configuration port
//   - controller state encoding
//   - upper bound on the number of sources and a priority-encode helper
// ----------------------------------------------------------------------------
package riscv_irq_ctrl_pkg;

   // Hard ceiling on NUM_SRC; the priority helper is sized for it.
   localparam int MAX_SRC = 32;

   // Register select values on cfg_addr.
   localparam logic [1:0] ADDR_ENABLE  = 2'd0;
   localparam logic [1:0] ADDR_MODE    = 2'd1;
   localparam logic [1:0] ADDR_PENDING = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

   // Index of the lowest set bit (index 0 = highest priority).
   // Returns 0 for an empty vector; callers qualify with a separate |vec.
   function automatic logic [4:0] lowest_set_idx(input logic [MAX_SRC-1:0] vec);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         idx = vec[i] ? 5'(i) : idx;
      end
      return idx;
   endfunction

endpackage : riscv_irq_ctrl_pkg

// File: rtl/riscv_irq_sync.sv
// ----------------------------------------------------------------------------
// riscv_irq_sync
// Single-bit synchroniser for one raw interrupt line, with an optional
// rising-edge detector on the synchronised value.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   d     in   raw asynchronous input
//   s     out  synchronised level (SYNC_STAGES flops after d)
//   rise  out  s & ~s delayed one cycle (tied 0 when EDGE_OUT = 0)
// ----------------------------------------------------------------------------
module riscv_irq_sync #(
   parameter int   SYNC_STAGES = 2,    // legal range 2..3
   parameter logic EDGE_OUT    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s_dly_q;
   logic                   s_dly_d;

   // Next-state for the synchroniser chain and the one-cycle delayed copy.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], d};
      s_dly_d = sync_q[SYNC_STAGES-1];
   end

   // Synchroniser and delay flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         s_dly_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         s_dly_q <= s_dly_d;
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   if (EDGE_OUT) begin : g_edge
      assign rise = sync_q[SYNC_STAGES-1] & ~s_dly_q;
   end else begin : g_no_edge
      assign rise = 1'b0;
   end

endmodule : riscv_irq_sync

// File: rtl/riscv_irq_ctrl.sv
// ----------------------------------------------------------------------------
// riscv_irq_ctrl
// Fixed-priority interrupt controller for the RISC-V core. Each of NUM_SRC
// sources is synchronised, can be enabled, and is treated as level or edge.
// One request at a time is offered to the core; the core claims it with
// irq_ack and retires it with irq_eoi (no nesting).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   irq_src             raw asynchronous source lines
//   cfg_we/addr/wdata   register write port (0 ENABLE, 1 MODE,
//                       2 PENDING write-1-to-clear, 3 STATUS read-only)
//   cfg_rdata           combinational read of register at cfg_addr
//   irq_req, irq_id     registered request and source index to the core
//   irq_ack, irq_eoi    claim and end-of-interrupt pulses from the core
// STATUS layout: bit NUM_SRC-1 = in-service valid, low ID_W bits = id.
// ----------------------------------------------------------------------------
module riscv_irq_ctrl
   import riscv_irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC     = 8,   // legal range 2..MAX_SRC
   parameter int SYNC_STAGES = 2,   // legal range 2..3
   parameter int ID_W        = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [NUM_SRC-1:0] cfg_wdata,
   output logic [NUM_SRC-1:0] cfg_rdata,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   input  logic               irq_eoi
);

   logic [NUM_SRC-1:0] s_vec;
   logic [NUM_SRC-1:0] rise_vec;

   logic [NUM_SRC-1:0] enable_q,  enable_d;
   logic [NUM_SRC-1:0] mode_q,    mode_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   irq_state_t         state_q,   state_d;
   logic               irq_req_q, irq_req_d;
   logic [ID_W-1:0]    irq_id_q,  irq_id_d;
   logic [ID_W-1:0]    isr_id_q,  isr_id_d;

   logic [NUM_SRC-1:0] cand_vec_s;
   logic               cand_any_s;
   logic [ID_W-1:0]    cand_id_s;
   logic               claim_s;
   logic [NUM_SRC-1:0] one_s;
   logic [NUM_SRC-1:0] clr_vec_s;
   logic [NUM_SRC-1:0] status_s;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      riscv_irq_sync #(
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE_OUT    (1'b1)
      ) u_sync (
         .clk  (clk),
         .rst  (rst),
         .d    (irq_src[g]),
         .s    (s_vec[g]),
         .rise (rise_vec[g])
      );
   end

   // Highest-priority enabled pending source.
   always_comb begin
      cand_vec_s = pending_q & enable_q;
      cand_any_s = |cand_vec_s;
      cand_id_s  = ID_W'(lowest_set_idx(MAX_SRC'(cand_vec_s)));
   end

   // Request/claim state machine next-state and registered outputs.
   // A vanished candidate wins over a same-cycle ack: nothing is left to claim.
   always_comb begin
      state_d   = state_q;
      irq_req_d = irq_req_q;
      irq_id_d  = irq_id_q;
      isr_id_d  = isr_id_q;
      claim_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cand_any_s) begin
               state_d   = REQ;
               irq_req_d = 1'b1;
               irq_id_d  = cand_id_s;
            end else begin
               irq_req_d = 1'b0;
            end
         end
         REQ: begin
            if (!cand_any_s) begin
               state_d   = IDLE;
               irq_req_d = 1'b0;
            end else if (irq_ack) begin
               // The core claimed the id it was shown, i.e. irq_id_q.
               state_d   = SERVICE;
               irq_req_d = 1'b0;
               isr_id_d  = irq_id_q;
               claim_s   = 1'b1;
            end else begin
               irq_req_d = 1'b1;
               irq_id_d  = cand_id_s;
            end
         end
         SERVICE: begin
            // eoi takes precedence; ack is meaningless here.
            if (irq_eoi) begin
               state_d  = IDLE;
               isr_id_d = '0;
            end else begin
               state_d  = SERVICE;
            end
         end
         default: begin
            state_d   = IDLE;
            irq_req_d = 1'b0;
            isr_id_d  = '0;
         end
      endcase
   end

   // Configuration registers and pending latches. Edge sources: a new edge
   // beats a same-cycle clear (claim or W1C). Level sources follow s.
   always_comb begin
      one_s     = {{(NUM_SRC-1){1'b0}}, 1'b1};
      clr_vec_s = '0;
      if (claim_s) begin
         clr_vec_s = one_s << irq_id_q;
      end else begin
         clr_vec_s = '0;
      end
      if (cfg_we && (cfg_addr == ADDR_PENDING)) begin
         clr_vec_s = clr_vec_s | cfg_wdata;
      end else begin
         clr_vec_s = clr_vec_s;
      end
      if (cfg_we && (cfg_addr == ADDR_ENABLE)) begin
         enable_d = cfg_wdata;
      end else begin
         enable_d = enable_q;
      end
      if (cfg_we && (cfg_addr == ADDR_MODE)) begin
         mode_d = cfg_wdata;
      end else begin
         mode_d = mode_q;
      end
      pending_d = (mode_q & (rise_vec | (pending_q & ~clr_vec_s)))
                | (~mode_q & s_vec);
   end

   // Combinational register read-back.
   always_comb begin
      status_s              = '0;
      status_s[ID_W-1:0]    = isr_id_q;
      status_s[NUM_SRC-1]   = (state_q == SERVICE);
      case (cfg_addr)
         ADDR_ENABLE:  cfg_rdata = enable_q;
         ADDR_MODE:    cfg_rdata = mode_q;
         ADDR_PENDING: cfg_rdata = pending_q;
         ADDR_STATUS:  cfg_rdata = status_s;
         default:      cfg_rdata = '0;
      endcase
   end

   // State, configuration and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enable_q  <= '0;
         mode_q    <= '0;
         pending_q <= '0;
         state_q   <= IDLE;
         irq_req_q <= 1'b0;
         irq_id_q  <= '0;
         isr_id_q  <= '0;
      end else begin
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         pending_q <= pending_d;
         state_q   <= state_d;
         irq_req_q <= irq_req_d;
         irq_id_q  <= irq_id_d;
         isr_id_q  <= isr_id_d;
      end
   end

   assign irq_req = irq_req_q;
   assign irq_id  = irq_id_q;

endmodule : riscv_irq_ctrl
